kbd_event_sequencer: RTL and testbench

KBD_EVENT_SEQUENCER -- requirements
Module: kbd_event_sequencer

---
 rtl/kbd_pkg.sv | 21 ++
 rtl/kbd_event_sequencer.sv | 127 ++++++++++++
 tb/tb_kbd_event_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared PS/2 keyboard constants and sequencer state encoding.
// Imported by kbd_event_sequencer.
package kbd_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;
   localparam logic [7:0] PS2_BAT = 8'hAA;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK,
      ST_EMIT
   } kbd_state_t;

   function automatic logic is_prefix(input logic [7:0] b);
      return (b == PS2_EXT) || (b == PS2_BRK);
   endfunction

endpackage

// File: rtl/kbd_event_sequencer.sv
// Turns a PS/2 scan byte stream (E0/F0 prefixes) into key events.
// Ports: rx_valid/rx_data/rx_ready pop a byte FIFO; evt_* is a
// valid/ready event output; held/last_code/key_cnt track the held
// key; proto_err is a sticky prefix/timeout error flag.
module kbd_event_sequencer
   import kbd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       rx_ready,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [7:0] evt_code,
   output logic       evt_ext,
   output logic       evt_make,
   output logic       evt_repeat,
   output logic       held,
   output logic [7:0] last_code,
   output logic [7:0] key_cnt,
   output logic       proto_err
);

   localparam int TW =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   kbd_state_t    state;
   logic [TW-1:0] tmo_cnt;
   logic          held_ext;

   logic take;
   logic in_pfx;
   logic ev_ext;
   logic ev_make;
   logic match;
   logic bat_drop;
   logic go_ext;
   logic go_brk;
   logic bad_pfx;
   logic is_code;

   assign take   = rx_valid & rx_ready;
   assign in_pfx = (state == ST_EXT) || (state == ST_BRK) ||
                   (state == ST_EXT_BRK);

   always_comb begin
      ev_ext   = (state == ST_EXT) || (state == ST_EXT_BRK);
      ev_make  = (state == ST_IDLE) || (state == ST_EXT);
      // last_code always names the held key while held=1
      match    = held && (rx_data == last_code) &&
                 (ev_ext == held_ext);
      bat_drop = (state == ST_IDLE) && (rx_data == PS2_BAT);
      go_ext   = (state == ST_IDLE) && (rx_data == PS2_EXT);
      go_brk   = ((state == ST_IDLE) || (state == ST_EXT)) &&
                 (rx_data == PS2_BRK);
      bad_pfx  = is_prefix(rx_data) && !go_ext && !go_brk;
      is_code  = !is_prefix(rx_data) && !bat_drop;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         tmo_cnt    <= '0;
         rx_ready   <= 1'b1;
         evt_valid  <= 1'b0;
         evt_code   <= 8'h00;
         evt_ext    <= 1'b0;
         evt_make   <= 1'b0;
         evt_repeat <= 1'b0;
         held       <= 1'b0;
         held_ext   <= 1'b0;
         last_code  <= 8'h00;
         key_cnt    <= 8'h00;
         proto_err  <= 1'b0;
      end else if (state == ST_EMIT) begin
         if (evt_ready) begin
            state     <= ST_IDLE;
            rx_ready  <= 1'b1;
            evt_valid <= 1'b0;
         end
      end else if (take) begin
         tmo_cnt <= '0;
         unique case (1'b1)
            bat_drop: state <= ST_IDLE;
            go_ext:   state <= ST_EXT;
            go_brk:   state <= (state == ST_IDLE) ?
                               ST_BRK : ST_EXT_BRK;
            bad_pfx: begin
               proto_err <= 1'b1;
               state     <= ST_IDLE;
            end
            is_code: begin
               state      <= ST_EMIT;
               rx_ready   <= 1'b0;
               evt_valid  <= 1'b1;
               evt_code   <= rx_data;
               evt_ext    <= ev_ext;
               evt_make   <= ev_make;
               evt_repeat <= ev_make && match;
               if (ev_make && !match) begin
                  held      <= 1'b1;
                  held_ext  <= ev_ext;
                  last_code <= rx_data;
                  key_cnt   <= key_cnt + 8'd1;
               end
               if (!ev_make && match)
                  held <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end else if (in_pfx) begin
         // silence while a prefix waits for its follow-up byte
         if (tmo_cnt == TMO_LAST) begin
            proto_err <= 1'b1;
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end
      end
   end

endmodule

// File: tb/tb_kbd_event_sequencer.sv
// Scoreboard bench for kbd_event_sequencer: directed PS/2 sequences
// plus randomized token streams against a byte-level reference model.
module tb_kbd_event_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_ready;
   logic       evt_valid;
   logic       evt_ready = 1'b0;
   logic [7:0] evt_code;
   logic       evt_ext;
   logic       evt_make;
   logic       evt_repeat;
   logic       held;
   logic [7:0] last_code;
   logic [7:0] key_cnt;
   logic       proto_err;

   kbd_event_sequencer #(.TIMEOUT_CYCLES(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_code   (evt_code),
      .evt_ext    (evt_ext),
      .evt_make   (evt_make),
      .evt_repeat (evt_repeat),
      .held       (held),
      .last_code  (last_code),
      .key_cnt    (key_cnt),
      .proto_err  (proto_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       mk;
      logic       rep;
      logic       held;
      logic [7:0] last;
      logic [7:0] cnt;
   } exp_t;

   int   errs = 0;
   int   checks = 0;
   int   cyc = 0;
   int   gaps = 0;
   int   ready_mode = 0;
   logic gap_en = 1'b0;

   logic [7:0] src[$];
   exp_t       expq[$];
   int         lat[$];
   logic [7:0] pfx[$];

   logic       m_held = 1'b0;
   logic [7:0] m_hcode = 8'h00;
   logic       m_hext = 1'b0;
   logic [7:0] m_last = 8'h00;
   logic [7:0] m_cnt = 8'h00;
   logic       m_err = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   // reference: a byte either extends the prefix list, aborts it,
   // or completes a key event described by the collected prefixes
   task automatic model_byte(input logic [7:0] b);
      exp_t e;
      logic ext;
      logic mk;
      logic same;
      if (b == 8'hE0) begin
         if (pfx.size() == 0) pfx.push_back(b);
         else begin m_err = 1'b1; pfx.delete(); end
      end else if (b == 8'hF0) begin
         if (pfx.size() == 0 ||
             (pfx.size() == 1 && pfx[0] == 8'hE0))
            pfx.push_back(b);
         else begin m_err = 1'b1; pfx.delete(); end
      end else if (b == 8'hAA && pfx.size() == 0) begin
      end else begin
         ext = 1'b0;
         mk  = 1'b1;
         foreach (pfx[i]) begin
            if (pfx[i] == 8'hE0) ext = 1'b1;
            if (pfx[i] == 8'hF0) mk = 1'b0;
         end
         pfx.delete();
         same = m_held && m_hcode == b && m_hext == ext;
         if (mk && !same) begin
            m_held  = 1'b1;
            m_hcode = b;
            m_hext  = ext;
            m_last  = b;
            m_cnt   = m_cnt + 8'd1;
         end
         if (!mk && same) m_held = 1'b0;
         e = '{code: b, ext: ext, mk: mk, rep: mk && same,
               held: m_held, last: m_last, cnt: m_cnt};
         expq.push_back(e);
         lat.push_back(cyc + 1);
      end
   endtask

   task automatic step();
      logic gap;
      @(posedge clk);
      #1;
      gap = gap_en && src.size() > 0 && gaps < 3 &&
            $urandom_range(0, 3) == 0;
      if (src.size() > 0 && !gap) begin
         rx_valid = 1'b1;
         rx_data  = src[0];
         gaps     = 0;
      end else begin
         rx_valid = 1'b0;
         if (gap) gaps++;
      end
      case (ready_mode)
         0:       evt_ready = 1'b1;
         1:       evt_ready = 1'($urandom_range(0, 1));
         default: evt_ready = 1'b0;
      endcase
      if (rx_valid && rx_ready) model_byte(src.pop_front());
   endtask

   task automatic drain();
      int n = 0;
      while ((src.size() > 0 || expq.size() > 0) && n < 20000) begin
         step();
         n++;
      end
      chk("drain_budget", 32'(n < 20000), 1);
      step();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      rx_valid = 1'b0;
      #1;
      chk("rst_outputs",
          {1'b0, rx_ready, evt_valid, evt_code, evt_ext, evt_make,
           evt_repeat, held, last_code, key_cnt, proto_err},
          {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0,
           1'b0, 1'b0, 8'h00, 8'h00, 1'b0});
      src.delete();
      expq.delete();
      lat.delete();
      pfx.delete();
      m_held = 1'b0; m_hcode = 8'h00; m_hext = 1'b0;
      m_last = 8'h00; m_cnt = 8'h00; m_err = 1'b0;
      gaps = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic push_token();
      logic [7:0] pool [6] = '{8'h1C, 8'h1B, 8'h75,
                               8'h6B, 8'h00, 8'hFF};
      logic [7:0] c;
      c = pool[$urandom_range(0, 5)];
      case ($urandom_range(0, 9))
         0, 1, 2: src.push_back(c);
         3:       begin src.push_back(8'hE0); src.push_back(c); end
         4, 5:    begin src.push_back(8'hF0); src.push_back(c); end
         6: begin
            src.push_back(8'hE0); src.push_back(8'hF0);
            src.push_back(c);
         end
         7: src.push_back(8'hAA);
         8: begin src.push_back(c); src.push_back(c); end
         default: begin
            case ($urandom_range(0, 4))
               0: begin src.push_back(8'hF0); src.push_back(8'hF0); end
               1: begin src.push_back(8'hE0); src.push_back(8'hE0); end
               2: begin src.push_back(8'hF0); src.push_back(8'hE0); end
               3: begin
                  src.push_back(8'hE0); src.push_back(8'hF0);
                  src.push_back(8'hE0);
               end
               default: begin
                  src.push_back(8'hE0); src.push_back(8'hF0);
                  src.push_back(8'hF0);
               end
            endcase
         end
      endcase
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (lat.size() > 0 && lat[0] == cyc) begin
            chk("latency_valid", 32'(evt_valid), 1);
            void'(lat.pop_front());
         end
         if (evt_valid)
            chk("spurious_evt", 32'(expq.size() > 0), 1);
         if (evt_valid && evt_ready && expq.size() > 0) begin
            e = expq.pop_front();
            chk("evt_fields",
                {20'h0, evt_code, evt_ext, evt_make, evt_repeat},
                {20'h0, e.code, e.ext, e.mk, e.rep});
            chk("key_state", {15'h0, held, last_code, key_cnt},
                {15'h0, e.held, e.last, e.cnt});
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      do_reset();

      // prefix followed by silence times out on the 8th idle cycle
      ready_mode = 0;
      gap_en = 1'b0;
      src.push_back(8'hE0);
      step();
      repeat (8) step();
      chk("tmo_not_early", 32'(proto_err), 0);
      step();
      chk("tmo_err", 32'(proto_err), 1);
      chk("tmo_ready", 32'(rx_ready), 1);
      m_err = 1'b1;
      pfx.delete();
      src.push_back(8'h1C);
      drain();

      do_reset();
      src.push_back(8'hF0);
      src.push_back(8'hF0);
      drain();
      chk("f0f0_err", 32'(proto_err), 1);
      chk("f0f0_ready", 32'(rx_ready), 1);
      src.push_back(8'h1C);
      drain();

      do_reset();
      src = '{8'h1C, 8'hF0, 8'h1C};
      drain();
      chk("mk_brk_cnt", 32'(key_cnt), 1);
      chk("mk_brk_held", 32'(held), 0);

      src = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
      drain();
      chk("ext_last", 32'(last_code), 32'h75);

      src = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
      drain();
      chk("repeat_cnt", 32'(key_cnt), 3);

      // backpressure: event held while downstream stalls
      ready_mode = 2;
      src = '{8'h1C, 8'hF0, 8'h1C};
      step();
      step();
      repeat (5) begin
         step();
         chk("bp_hold", {evt_valid, rx_ready, rx_valid}, 3'b101);
      end
      ready_mode = 0;
      step();
      @(negedge clk);
      #1;
      chk("bp_accept", 32'(expq.size()), 0);
      drain();
      chk("bp_cnt", 32'(key_cnt), 4);

      // reset while sitting in BRK with a key held and error set
      src = '{8'hE0, 8'hE0, 8'h1C, 8'hF0};
      drain();
      do_reset();
      src.push_back(8'h1C);
      drain();
      chk("post_rst_cnt", 32'(key_cnt), 1);

      // 256 new presses wrap the counter
      do_reset();
      ready_mode = 1;
      gap_en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         logic [7:0] c;
         logic       x;
         c = 8'(i);
         x = 1'b0;
         if (c == 8'hE0) begin c = 8'h01; x = 1'b1; end
         if (c == 8'hF0) begin c = 8'h02; x = 1'b1; end
         if (c == 8'hAA) begin c = 8'h03; x = 1'b1; end
         if (x) src.push_back(8'hE0);
         src.push_back(c);
         if (x) src.push_back(8'hE0);
         src.push_back(8'hF0);
         src.push_back(c);
      end
      drain();
      chk("wrap_cnt", 32'(key_cnt), 0);
      chk("wrap_held", 32'(held), 0);

      repeat (300) push_token();
      drain();
      chk("rand_err", 32'(proto_err), 32'(m_err));
      chk("rand_cnt", 32'(key_cnt), 32'(m_cnt));
      chk("rand_held", 32'(held), 32'(m_held));
      chk("rand_last", 32'(last_code), 32'(m_last));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
